shift_pipe: RTL and testbench

Pipelined, parametrised barrel shifter for the ALU datapath. It supports logical left, logical right, arithmetic right and rotate-left on a WIDTH-bit operand, with a shift amount of 0..WIDTH-1. It has one register stage per amount bit and a valid/ready handshake on both sides. A tag travels with each operation so the issuing logic can match results to requests.

---
 rtl/shift_pipe.sv | 113 +++++++++++
 tb/tb_shift_pipe.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL) with a tag carried alongside each operation.
// Latency is AMT_W edges from accept to out_valid. A stalled output freezes every stage, and in_ready drops in the same cycle.
module shift_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  // Register 0 captures the request unshifted; register k+1 applies the 2^k step.
  logic [AMT_W:0]                  vld_q, vld_d;
  logic [AMT_W:0][WIDTH-1:0]       dat_q, dat_d;
  logic [AMT_W:0][TAG_W-1:0]       tag_q, tag_d;
  logic [AMT_W-1:0][AMT_W-1:0]     amt_q, amt_d;
  logic [AMT_W-1:0][1:0]           op_q, op_d;
  logic [AMT_W-1:0]                sgn_q, sgn_d;
  logic                            zero_q, zero_d;
  logic                            stall;

  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d,
                                                  input logic [1:0] op,
                                                  input logic sign,
                                                  input int sh);
    logic [WIDTH-1:0] r;
    case (op)
      OP_SLL:  r = d << sh;
      OP_SRL:  r = d >> sh;
      OP_SRA:  r = ({WIDTH{sign}} << (WIDTH - sh)) | (d >> sh);
      default: r = (d << sh) | (d >> (WIDTH - sh));
    endcase
    return r;
  endfunction

  assign stall    = vld_q[AMT_W] & ~out_ready;
  assign in_ready = ~stall;

  always_comb begin
    vld_d  = vld_q;
    dat_d  = dat_q;
    tag_d  = tag_q;
    amt_d  = amt_q;
    op_d   = op_q;
    sgn_d  = sgn_q;
    zero_d = zero_q;
    if (!stall) begin
      vld_d[0] = in_valid;
      dat_d[0] = in_data;
      tag_d[0] = in_tag;
      amt_d[0] = in_amt;
      op_d[0]  = in_op;
      sgn_d[0] = in_data[WIDTH-1];
      for (int k = 0; k < AMT_W; k++) begin
        vld_d[k+1] = vld_q[k];
        tag_d[k+1] = tag_q[k];
        dat_d[k+1] = amt_q[k][k] ? shift_step(dat_q[k], op_q[k], sgn_q[k], 1 << k)
                                 : dat_q[k];
      end
      for (int k = 0; k < AMT_W - 1; k++) begin
        amt_d[k+1] = amt_q[k];
        op_d[k+1]  = op_q[k];
        sgn_d[k+1] = sgn_q[k];
      end
      zero_d = (dat_d[AMT_W] == '0);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_q  <= '0;
      dat_q  <= '0;
      tag_q  <= '0;
      amt_q  <= '0;
      op_q   <= '0;
      sgn_q  <= '0;
      zero_q <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      dat_q  <= dat_d;
      tag_q  <= tag_d;
      amt_q  <= amt_d;
      op_q   <= op_d;
      sgn_q  <= sgn_d;
      zero_q <= zero_d;
    end
  end

  // Only the top amount bit matters by the last shift step.
  logic unused_amt;
  assign unused_amt = ^amt_q[AMT_W-1][AMT_W-2:0];

  assign out_valid = vld_q[AMT_W];
  assign out_data  = dat_q[AMT_W];
  assign out_tag   = tag_q[AMT_W];
  assign out_zero  = zero_q;

endmodule

// File: tb/tb_shift_pipe.sv
// Randomised and directed bench for shift_pipe against a plain-arithmetic shift model.
module tb_shift_pipe;
  logic        clock, reset_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_zero;
  logic [31:0] in_data, out_data;
  logic [4:0]  in_amt;
  logic [1:0]  in_op;
  logic [3:0]  in_tag, out_tag;

  int n_tests = 0;
  int n_fail  = 0;

  shift_pipe #(.WIDTH(32), .TAG_W(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amt(in_amt), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_zero(out_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int amt, input logic [1:0] op);
    logic [63:0] dd;
    case (op)
      2'd0: return d << amt;
      2'd1: return d >> amt;
      2'd2: return 32'($signed(d) >>> amt);
      default: begin
        dd = {d, d} << amt;
        return dd[63:32];
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issues one request into an idle pipe and reports what comes back; no checking here.
  task automatic run_one(input logic [31:0] d, input int amt, input logic [1:0] op, input logic [3:0] tg,
                         output logic [31:0] res, output logic [3:0] rtag, output logic z, output int lat);
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = d; in_amt = amt[4:0]; in_op = op; in_tag = tg;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    res = out_data; rtag = out_tag; z = out_zero;
    tick();
  endtask

  task automatic test_reset();
    tick();
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_tag !== 4'h0 || out_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b d=%h t=%h z=%b, expected all 0", out_valid, out_data, out_tag, out_zero);
    end
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    tick();
    reset_n = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset: got rdy=%b v=%b expected rdy=1 v=0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    logic [31:0] vd [4] = '{32'hAAAAAAAA, 32'h80000000, 32'h80000000, 32'h12345678};
    int          va [4] = '{1, 4, 31, 8};
    logic [1:0]  vo [4] = '{2'd0, 2'd2, 2'd1, 2'd3};
    logic [31:0] ve [4] = '{32'h55555554, 32'hF8000000, 32'h00000001, 32'h34567812};
    logic [31:0] res; logic [3:0] rt; logic z; int lat;
    for (int i = 0; i < 4; i++) begin
      run_one(vd[i], va[i], vo[i], 4'(i + 9), res, rt, z, lat);
      n_tests++;
      if (res !== ve[i] || rt !== 4'(i + 9) || lat != 5) begin
        n_fail++;
        $display("FAIL basic_%0d: got d=%h t=%h lat=%0d expected d=%h t=%h lat=5", i, res, rt, lat, ve[i], 4'(i + 9));
      end
    end
  endtask

  task automatic test_zero();
    logic [31:0] vd [3] = '{32'h00000001, 32'h00000001, 32'hFFFFFFFF};
    int          va [3] = '{31, 1, 31};
    logic [1:0]  vo [3] = '{2'd0, 2'd1, 2'd2};
    logic [31:0] ve [3] = '{32'h80000000, 32'h00000000, 32'hFFFFFFFF};
    logic        vz [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] res; logic [3:0] rt; logic z; int lat;
    for (int i = 0; i < 3; i++) begin
      run_one(vd[i], va[i], vo[i], 4'(i + 1), res, rt, z, lat);
      n_tests++;
      if (res !== ve[i] || z !== vz[i] || lat != 5) begin
        n_fail++;
        $display("FAIL zero_%0d: got d=%h z=%b lat=%0d expected d=%h z=%b lat=5", i, res, z, lat, ve[i], vz[i]);
      end
    end
  endtask

  task automatic test_sweep();
    logic [31:0] qd [$]; logic [3:0] qt [$];
    int sent, got, first;
    logic [31:0] ed; logic [3:0] et;
    out_ready = 1'b1;
    for (int op = 0; op < 4; op++) begin
      sent = 0; got = 0; first = -1;
      for (int c = 0; c < 80 && got < 32; c++) begin
        in_valid = (sent < 32); in_data = 32'hAAAAAAAA; in_amt = sent[4:0];
        in_op = op[1:0]; in_tag = 4'($urandom);
        #1;
        if (in_valid) begin
          n_tests++;
          if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL sweep_ready op=%0d amt=%0d: got %b expected 1", op, sent, in_ready);
          end
        end
        if (in_valid && in_ready) begin
          qd.push_back(ref_shift(32'hAAAAAAAA, sent, op[1:0])); qt.push_back(in_tag); sent++;
        end
        if (out_valid) begin
          if (first < 0) first = c;
          n_tests++;
          if (qd.size() == 0) begin
            n_fail++;
            $display("FAIL sweep_extra op=%0d: got d=%h with no request outstanding, expected none", op, out_data);
          end else begin
            ed = qd.pop_front(); et = qt.pop_front();
            if (out_data !== ed || out_tag !== et || out_zero !== (ed == 0) || c != first + got) begin
              n_fail++;
              $display("FAIL sweep op=%0d n=%0d: got d=%h t=%h z=%b cyc=%0d expected d=%h t=%h z=%b cyc=%0d",
                       op, got, out_data, out_tag, out_zero, c, ed, et, ed == 0, first + got);
            end
          end
          got++;
        end
        tick();
      end
      in_valid = 1'b0;
      n_tests++;
      if (got != 32) begin
        n_fail++;
        $display("FAIL sweep_count op=%0d: got %0d results expected 32", op, got);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] qd [$]; logic [3:0] qt [$];
    int sent = 0, got = 0, hold = 0, amt;
    bit first_seen = 0;
    logic [31:0] hd, ed; logic [3:0] ht, et; logic [1:0] op;
    for (int c = 0; c < 80 && got < 8; c++) begin
      if (out_valid && !first_seen) begin first_seen = 1; hold = 3; end
      out_ready = (hold == 0);
      amt = $urandom_range(0, 31); op = 2'($urandom);
      in_valid = (sent < 8); in_data = $urandom; in_amt = amt[4:0]; in_op = op; in_tag = sent[3:0];
      #1;
      if (hold == 3) begin
        hd = out_data; ht = out_tag;
        n_tests++;
        if (in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_in_ready: got %b expected 0", in_ready);
        end
      end else if (hold > 0) begin
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== hd || out_tag !== ht) begin
          n_fail++;
          $display("FAIL bp_hold: got v=%b d=%h t=%h expected v=1 d=%h t=%h", out_valid, out_data, out_tag, hd, ht);
        end
      end
      if (in_valid && in_ready) begin
        qd.push_back(ref_shift(in_data, amt, op)); qt.push_back(in_tag); sent++;
      end
      if (out_valid && out_ready) begin
        n_tests++;
        ed = (qd.size() > 0) ? qd.pop_front() : 32'hX;
        et = (qt.size() > 0) ? qt.pop_front() : 4'hX;
        if (out_data !== ed || out_tag !== et || out_tag !== got[3:0]) begin
          n_fail++;
          $display("FAIL bp_result %0d: got d=%h t=%h expected d=%h t=%h", got, out_data, out_tag, ed, got[3:0]);
        end
        got++;
      end
      if (hold > 0) hold--;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (out_valid) got++;
      tick();
    end
    n_tests++;
    if (got != 8 || sent != 8) begin
      n_fail++;
      $display("FAIL bp_count: got sent=%0d recv=%0d expected 8/8", sent, got);
    end
  endtask

  task automatic test_bubbles();
    logic vin [10];
    logic obs [16];
    out_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      in_valid = (c < 10) ? (c % 2 == 0) : 1'b0;
      if (c < 10) vin[c] = in_valid;
      in_data = $urandom; in_amt = 5'($urandom); in_op = 2'($urandom); in_tag = 4'($urandom);
      tick();
      obs[c] = out_valid;
    end
    in_valid = 1'b0;
    for (int c = 5; c < 15; c++) begin
      n_tests++;
      if (obs[c] !== vin[c-5]) begin
        n_fail++;
        $display("FAIL bubble cyc=%0d: got out_valid=%b expected %b", c, obs[c], vin[c-5]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    bit stale = 0;
    logic [31:0] res; logic [3:0] rt; logic z; int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 32'hF0F0_0000 | i; in_amt = 5'd0; in_op = 2'd0; in_tag = 4'(i + 5);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    #3 reset_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_tag !== 4'h0 || out_zero !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset: got v=%b d=%h t=%h z=%b rdy=%b expected 0/0/0/0/1",
               out_valid, out_data, out_tag, out_zero, in_ready);
    end
    tick();
    reset_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (out_valid) stale = 1;
      tick();
    end
    n_tests++;
    if (stale) begin
      n_fail++;
      $display("FAIL mid_reset_stale: got a result after reset, expected none");
    end
    run_one(32'h0000_00F1, 3, 2'd3, 4'hC, res, rt, z, lat);
    n_tests++;
    if (res !== 32'h0000_0788 || rt !== 4'hC || lat != 5) begin
      n_fail++;
      $display("FAIL mid_reset_new: got d=%h t=%h lat=%0d expected d=00000788 t=c lat=5", res, rt, lat);
    end
  endtask

  task automatic test_random();
    logic [31:0] qd [$]; logic [3:0] qt [$];
    logic pv = 0, pr = 0; logic [31:0] pd = 0; logic [3:0] pt = 0;
    logic [31:0] ed; logic [3:0] et; logic [1:0] op;
    int amt, acc = 0, dep = 0;
    for (int c = 0; c < 400; c++) begin
      if (pv && !pr) begin
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== pd || out_tag !== pt) begin
          n_fail++;
          $display("FAIL rnd_hold cyc=%0d: got v=%b d=%h t=%h expected v=1 d=%h t=%h", c, out_valid, out_data, out_tag, pd, pt);
        end
      end
      out_ready = (c >= 360) || ($urandom_range(0, 9) < 7);
      amt = $urandom_range(0, 31); op = 2'($urandom);
      in_valid = (c < 340) && ($urandom_range(0, 9) < 6);
      in_data = $urandom; in_amt = amt[4:0]; in_op = op; in_tag = 4'($urandom);
      #1;
      if (in_valid && in_ready) begin
        qd.push_back(ref_shift(in_data, amt, op)); qt.push_back(in_tag); acc++;
      end
      if (out_valid && out_ready) begin
        n_tests++;
        ed = (qd.size() > 0) ? qd.pop_front() : 32'hX;
        et = (qt.size() > 0) ? qt.pop_front() : 4'hX;
        if (out_data !== ed || out_tag !== et || out_zero !== (ed == 0)) begin
          n_fail++;
          $display("FAIL rnd_result %0d: got d=%h t=%h z=%b expected d=%h t=%h z=%b", dep, out_data, out_tag, out_zero, ed, et, ed == 0);
        end
        dep++;
      end
      pv = out_valid; pr = out_ready; pd = out_data; pt = out_tag;
      tick();
    end
    n_tests++;
    if (acc != dep || qd.size() != 0) begin
      n_fail++;
      $display("FAIL rnd_count: got accepted=%0d departed=%0d expected equal", acc, dep);
    end
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_data = '0; in_amt = '0; in_op = '0; in_tag = '0;
    test_reset();
    test_basic();
    test_zero();
    test_sweep();
    test_backpressure();
    test_bubbles();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
